turbo_output_mux: RTL and testbench
===================================

TURBO_OUTPUT_MUX -- requirements
Module: turbo_output_mux

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock shared with both constituent encoders.
REQ-003 aclr  in  1  asynchronous active-high reset.
REQ-004 data_ready  in  1  one-cycle block-start pulse, the same pulse the encoders receive.
REQ-005 K  in  1  block size select, sampled with data_ready: 0 = 1056 bits, 1 = 6144 bits.
REQ-006 x1, z1  in  1 each  systematic and parity outputs of encoder 1.
REQ-007 x2, z2  in  1 each  systematic and parity outputs of encoder 2, which is fed the interleaved data.
REQ-008 d0, d1, d2  out  1 each  registered output streams d(0), d(1), d(2).
REQ-009 out_valid  out  1  high when d0..d2 carry a column.
REQ-010 sop, eop  out  1 each  first-column and last-column markers, each qualified by out_valid.
REQ-011 busy  out  1  high from the edge that samples data_ready until the edge that emits eop, inclusive.
REQ-012 err  out  1  sticky flag: data_ready arrived while busy.

Function
REQ-013 Timing convention: edge 0 is the edge sampling data_ready. Input bit k (k = 0..K+2) is sampled at edge k+1.
REQ-014 Data phase, k = 0..K-1: at edge k+1, set d0=x1, d1=z1, d2=z2 and out_valid=1. x2 is ignored in this phase.
REQ-015 sop SHALL be 1 only with the column for k=0. Latency from the input bit to its output is 1 cycle.
REQ-016 Tail capture: x1, z1, x2, z2 SHALL be stored at edges K+1, K+2, K+3 (12 bits total). out_valid=0 after each of these edges.
REQ-017 Tail output: four columns SHALL be emitted after edges K+4..K+7, with out_valid=1 on each.
REQ-018 Tail column 0: d0=x1[K], d1=z1[K], d2=x1[K+1].
REQ-019 Tail column 1: d0=z1[K+1], d1=x1[K+2], d2=z1[K+2].
REQ-020 Tail column 2: d0=x2[K], d1=z2[K], d2=x2[K+1].
REQ-021 Tail column 3: d0=z2[K+1], d1=x2[K+2], d2=z2[K+2]. eop=1 with this column.
REQ-022 Each block SHALL produce exactly K+4 valid columns.
REQ-023 State machine: IDLE -> DATA on data_ready; DATA -> TAIL_CAP after edge K; TAIL_CAP -> TAIL_OUT after edge K+3; TAIL_OUT -> IDLE after edge K+7.
REQ-024 The cycle counter SHALL be 13 bits, unsigned, and SHALL never wrap within a block (maximum count 6151).
REQ-025 When out_valid=0, d0..d2, sop and eop SHALL be driven to 0.
REQ-026 data_ready while busy SHALL be ignored: the block is not restarted and K is not resampled. err is set at the next edge.
REQ-027 data_ready on the same edge as eop SHALL be ignored, and err set. data_ready one cycle after eop SHALL be accepted normally.
REQ-028 K SHALL be latched at edge 0 and held for the whole block. Changes on the K pin mid-block have no effect.

Reset
REQ-029 While aclr is high: state=IDLE, counter=0, tail registers=0, and d0, d1, d2, out_valid, sop, eop, busy, err all equal 0.
REQ-030 aclr asserted mid-block SHALL abort the block immediately, with no further valid columns. The first data_ready after release starts a fresh block.

Configuration
REQ-031 Macro TURBO_OUTPUT_MUX_DEBUG_EN defined: add output debug_cnt [12:0] (current counter) and output debug_state [1:0] (IDLE=0, DATA=1, TAIL_CAP=2, TAIL_OUT=3). Both SHALL be 0 under reset.
REQ-032 Macro not defined: neither port exists, and all other behaviour SHALL be identical.

Verification
REQ-033 K=0, alternating data, tail inputs x1=1,0,0 / z1=0,1,0 / x2=0,0,1 / z2=1,1,0 -> 1060 valid columns, with tail columns (d0d1d2) = 100, 100, 010, 110 and eop on the last.
REQ-034 K=1, random data -> 6148 valid columns; data columns equal (x1, z1, z2) delayed 1 cycle; sop on edge 1 only; out_valid=0 after edges 6145..6147.
REQ-035 data_ready re-pulsed at edge 500 of a K=0 block -> block completes unchanged, err=1 afterward and held until aclr.
REQ-036 aclr pulsed at edge 300 of a K=1 block -> all outputs 0 immediately; next data_ready with K=0 yields exactly 1060 columns and err=0.
REQ-037 Two K=0 blocks back-to-back, with the second data_ready one cycle after eop -> 2 x 1060 columns, no err, and busy low for exactly that one cycle between blocks.
REQ-038 Build with TURBO_OUTPUT_MUX_DEBUG_EN -> debug_state sequence 0,1,2,3,0 with debug_cnt=1056 on the DATA->TAIL_CAP transition for K=0. Build without it -> ports absent and REQ-033 passes.

Source files
------------

// File: rtl/turbo_output_mux_if.sv
// Encoder-side inputs and multiplexed output streams of the turbo output mux.
// No backpressure: the master drives encoder bits every cycle, the slave emits columns as they form.
interface turbo_output_mux_if;
    logic data_ready;
    logic K;
    logic x1;
    logic z1;
    logic x2;
    logic z2;
    logic d0;
    logic d1;
    logic d2;
    logic out_valid;
    logic sop;
    logic eop;
    logic busy;
    logic err;

    modport master (
        output data_ready, K, x1, z1, x2, z2,
        input  d0, d1, d2, out_valid, sop, eop, busy, err
    );

    modport slave (
        input  data_ready, K, x1, z1, x2, z2,
        output d0, d1, d2, out_valid, sop, eop, busy, err
    );
endinterface

// File: rtl/turbo_output_mux.sv
// Turbo output mux: K data columns (x1,z1,z2) then 4 trellis-tail columns; TURBO_OUTPUT_MUX_DEBUG_EN adds debug_cnt/debug_state.
// Latency 1 cycle input-to-column; no backpressure, a data_ready arriving mid-block is dropped and flagged on err.
module turbo_output_mux (
    input  logic              clk,
    input  logic              aclr,
    turbo_output_mux_if.slave bus
`ifdef TURBO_OUTPUT_MUX_DEBUG_EN
    ,
    output logic [12:0]       debug_cnt,
    output logic [1:0]        debug_state
`endif
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DATA     = 2'd1,
        TAIL_CAP = 2'd2,
        TAIL_OUT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [12:0] cnt_q, cnt_d;
    logic        ksel_q, ksel_d;
    logic [12:0] k_len;
    logic [12:0] rel;
    logic [12:0] col;

    logic [2:0]  tx1_q, tx1_d;
    logic [2:0]  tz1_q, tz1_d;
    logic [2:0]  tx2_q, tx2_d;
    logic [2:0]  tz2_q, tz2_d;
    logic [2:0]  tail_col;

    logic        d0_q, d0_d;
    logic        d1_q, d1_d;
    logic        d2_q, d2_d;
    logic        out_valid_q, out_valid_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;

    // cnt_q equals the index of the last edge since edge 0, so it tops out at K+7.
    assign k_len = ksel_q ? 13'd6144 : 13'd1056;
    assign rel   = cnt_q - k_len;
    assign col   = rel - 13'd3;

    always_comb begin
        tail_col = 3'b000;
        if (col == 13'd0) begin
            tail_col = {tx1_q[0], tz1_q[0], tx1_q[1]};
        end else if (col == 13'd1) begin
            tail_col = {tz1_q[1], tx1_q[2], tz1_q[2]};
        end else if (col == 13'd2) begin
            tail_col = {tx2_q[0], tz2_q[0], tx2_q[1]};
        end else if (col == 13'd3) begin
            tail_col = {tz2_q[1], tx2_q[2], tz2_q[2]};
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ksel_d      = ksel_q;
        tx1_d       = tx1_q;
        tz1_d       = tz1_q;
        tx2_d       = tx2_q;
        tz2_d       = tz2_q;
        d0_d        = 1'b0;
        d1_d        = 1'b0;
        d2_d        = 1'b0;
        out_valid_d = 1'b0;
        sop_d       = 1'b0;
        eop_d       = 1'b0;
        busy_d      = busy_q;
        err_d       = err_q | (bus.data_ready & busy_q);

        case (state_q)
            IDLE: begin
                if (bus.data_ready) begin
                    state_d = DATA;
                    cnt_d   = 13'd0;
                    ksel_d  = bus.K;
                    busy_d  = 1'b1;
                end
            end
            DATA: begin
                cnt_d       = cnt_q + 13'd1;
                out_valid_d = 1'b1;
                d0_d        = bus.x1;
                d1_d        = bus.z1;
                d2_d        = bus.z2;
                sop_d       = (cnt_q == 13'd0);
                if (cnt_q == k_len - 13'd1) begin
                    state_d = TAIL_CAP;
                end
            end
            TAIL_CAP: begin
                cnt_d = cnt_q + 13'd1;
                for (int j = 0; j < 3; j++) begin
                    if (rel == 13'(j)) begin
                        tx1_d[j] = bus.x1;
                        tz1_d[j] = bus.z1;
                        tx2_d[j] = bus.x2;
                        tz2_d[j] = bus.z2;
                    end
                end
                if (rel == 13'd2) begin
                    state_d = TAIL_OUT;
                end
            end
            TAIL_OUT: begin
                cnt_d       = cnt_q + 13'd1;
                out_valid_d = 1'b1;
                d0_d        = tail_col[2];
                d1_d        = tail_col[1];
                d2_d        = tail_col[0];
                if (col == 13'd3) begin
                    eop_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q     <= IDLE;
            cnt_q       <= 13'd0;
            ksel_q      <= 1'b0;
            tx1_q       <= 3'b000;
            tz1_q       <= 3'b000;
            tx2_q       <= 3'b000;
            tz2_q       <= 3'b000;
            d0_q        <= 1'b0;
            d1_q        <= 1'b0;
            d2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ksel_q      <= ksel_d;
            tx1_q       <= tx1_d;
            tz1_q       <= tz1_d;
            tx2_q       <= tx2_d;
            tz2_q       <= tz2_d;
            d0_q        <= d0_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            out_valid_q <= out_valid_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign bus.d0        = d0_q;
    assign bus.d1        = d1_q;
    assign bus.d2        = d2_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sop       = sop_q;
    assign bus.eop       = eop_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;

`ifdef TURBO_OUTPUT_MUX_DEBUG_EN
    assign debug_cnt   = cnt_q;
    assign debug_state = state_q;
`endif
endmodule

// File: tb/tb_turbo_output_mux.sv
// Randomized self-checking bench for turbo_output_mux against a column-list reference model.
module tb_turbo_output_mux;
    localparam int MAXE = 6200;

    logic clk = 1'b0;
    logic aclr;
    always #5 clk = ~clk;

    turbo_output_mux_if bus();

`ifdef TURBO_OUTPUT_MUX_DEBUG_EN
    logic [12:0] debug_cnt;
    logic [1:0]  debug_state;
    int          dbg_state [MAXE];
    int          dbg_cnt   [MAXE];
`endif

    turbo_output_mux dut (
        .clk  (clk),
        .aclr (aclr),
        .bus  (bus)
`ifdef TURBO_OUTPUT_MUX_DEBUG_EN
        ,
        .debug_cnt   (debug_cnt),
        .debug_state (debug_state)
`endif
    );

    typedef struct {
        int       e;
        bit [2:0] d;
        bit       sop;
        bit       eop;
    } col_t;

    int   errors = 0;
    int   checks = 0;
    bit   sx1 [MAXE];
    bit   sz1 [MAXE];
    bit   sx2 [MAXE];
    bit   sz2 [MAXE];
    bit   ov  [MAXE];
    bit   bz  [MAXE];
    bit   er  [MAXE];
    col_t got[$];
    col_t exp_q[$];

    // mode 0: alternating data with the fixed tail pattern; mode 1: fully random
    task automatic gen_stim(input int klen, input int mode);
        for (int k = 0; k < klen + 3; k++) begin
            if (mode == 0) begin
                sx1[k] = (k % 2) != 0;
                sz1[k] = (k % 2) == 0;
                sx2[k] = 1'($urandom);
                sz2[k] = ((k / 2) % 2) != 0;
            end else begin
                sx1[k] = 1'($urandom);
                sz1[k] = 1'($urandom);
                sx2[k] = 1'($urandom);
                sz2[k] = 1'($urandom);
            end
        end
        if (mode == 0) begin
            sx1[klen] = 1; sx1[klen+1] = 0; sx1[klen+2] = 0;
            sz1[klen] = 0; sz1[klen+1] = 1; sz1[klen+2] = 0;
            sx2[klen] = 0; sx2[klen+1] = 0; sx2[klen+2] = 1;
            sz2[klen] = 1; sz2[klen+1] = 1; sz2[klen+2] = 0;
        end
    endtask

    // Expected columns straight from the output format: data then four tail columns.
    task automatic build_expected(input int klen);
        exp_q.delete();
        for (int k = 0; k < klen; k++)
            exp_q.push_back('{k + 1, {sx1[k], sz1[k], sz2[k]}, k == 0, 1'b0});
        exp_q.push_back('{klen + 4, {sx1[klen],   sz1[klen],   sx1[klen+1]}, 1'b0, 1'b0});
        exp_q.push_back('{klen + 5, {sz1[klen+1], sx1[klen+2], sz1[klen+2]}, 1'b0, 1'b0});
        exp_q.push_back('{klen + 6, {sx2[klen],   sz2[klen],   sx2[klen+1]}, 1'b0, 1'b0});
        exp_q.push_back('{klen + 7, {sz2[klen+1], sx2[klen+2], sz2[klen+2]}, 1'b0, 1'b1});
    endtask

    function automatic int count_mismatch(output int first);
        int n = 0;
        first = -1;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            if (got[i].e != exp_q[i].e || got[i].d != exp_q[i].d ||
                got[i].sop != exp_q[i].sop || got[i].eop != exp_q[i].eop) begin
                if (first < 0) first = i;
                n++;
            end
        end
        return n;
    endfunction

    // Called at a negedge; drives data_ready now so the next posedge is edge 0.
    task automatic run_block(input bit ksel, input int last_e, input int pulse_e);
        int klen = ksel ? 6144 : 1056;
        got.delete();
        bus.data_ready = 1'b1;
        bus.K          = ksel;
        for (int e = 0; e <= last_e; e++) begin
            @(posedge clk);
            @(negedge clk);
            ov[e] = bus.out_valid;
            bz[e] = bus.busy;
            er[e] = bus.err;
`ifdef TURBO_OUTPUT_MUX_DEBUG_EN
            dbg_state[e] = int'(debug_state);
            dbg_cnt[e]   = int'(debug_cnt);
`endif
            if (bus.out_valid)
                got.push_back('{e, {bus.d0, bus.d1, bus.d2}, bus.sop, bus.eop});
            bus.data_ready = (e + 1 == pulse_e);
            bus.K          = (e + 1 == pulse_e) ? ~ksel : 1'($urandom);
            if (e < klen + 3) begin
                bus.x1 = sx1[e]; bus.z1 = sz1[e]; bus.x2 = sx2[e]; bus.z2 = sz2[e];
            end else begin
                bus.x1 = 1'($urandom); bus.z1 = 1'($urandom);
                bus.x2 = 1'($urandom); bus.z2 = 1'($urandom);
            end
        end
    endtask

    task automatic do_reset();
        aclr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        aclr = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        aclr = 1'b1;
        bus.data_ready = 0; bus.K = 0; bus.x1 = 0; bus.z1 = 0; bus.x2 = 0; bus.z2 = 0;
        repeat (3) @(negedge clk);
        obs = {bus.d0, bus.d1, bus.d2, bus.out_valid, bus.sop, bus.eop, bus.busy, bus.err};
        checks++;
        if (obs !== 8'h00) begin
            errors++; $display("FAIL reset_outputs: got %b want 00000000", obs);
        end
`ifdef TURBO_OUTPUT_MUX_DEBUG_EN
        checks++;
        if ({debug_cnt, debug_state} !== 15'd0) begin
            errors++; $display("FAIL reset_debug: got cnt=%0d state=%0d want 0/0", debug_cnt, debug_state);
        end
`endif
        aclr = 1'b0;
        repeat (2) @(negedge clk);
        obs = {bus.d0, bus.d1, bus.d2, bus.out_valid, bus.sop, bus.eop, bus.busy, bus.err};
        checks++;
        if (obs !== 8'h00) begin
            errors++; $display("FAIL idle_outputs: got %b want 00000000", obs);
        end
    endtask

    task automatic test_k0_pattern();
        int n, fi;
        gen_stim(1056, 0);
        build_expected(1056);
        run_block(1'b0, 1056 + 12, -1);
        checks++;
        if (got.size() !== 1060) begin
            errors++; $display("FAIL k0_count: got %0d want 1060", got.size());
        end
        n = count_mismatch(fi);
        checks++;
        if (n !== 0) begin
            errors++; $display("FAIL k0_columns: %0d mismatches, first at index %0d", n, fi);
        end
        if (got.size() >= 1060) begin
            checks++;
            if ({got[1056].d, got[1057].d, got[1058].d, got[1059].d, got[1059].eop} !== 13'b100_100_010_110_1) begin
                errors++;
                $display("FAIL k0_tail: got %b %b %b %b eop=%b want 100 100 010 110 eop=1",
                         got[1056].d, got[1057].d, got[1058].d, got[1059].d, got[1059].eop);
            end
        end
        checks++;
        if ({bz[0], bz[1062], bz[1063], er[1068]} !== 4'b1100) begin
            errors++; $display("FAIL k0_busy_err: got %b want 1100", {bz[0], bz[1062], bz[1063], er[1068]});
        end
    endtask

    task automatic test_k1_random();
        int n, fi;
        gen_stim(6144, 1);
        build_expected(6144);
        run_block(1'b1, 6144 + 10, -1);
        checks++;
        if (got.size() !== 6148) begin
            errors++; $display("FAIL k1_count: got %0d want 6148", got.size());
        end
        n = count_mismatch(fi);
        checks++;
        if (n !== 0) begin
            errors++; $display("FAIL k1_columns: %0d mismatches, first at index %0d", n, fi);
        end
        checks++;
        if ({ov[6144], ov[6145], ov[6146], ov[6147], ov[6148]} !== 5'b10001) begin
            errors++;
            $display("FAIL k1_tail_gap: got %b want 10001", {ov[6144], ov[6145], ov[6146], ov[6147], ov[6148]});
        end
    endtask

    task automatic test_err_midblock();
        int n, fi;
        gen_stim(1056, 1);
        build_expected(1056);
        run_block(1'b0, 1056 + 20, 500);
        n = count_mismatch(fi);
        checks++;
        if (got.size() !== 1060 || n !== 0) begin
            errors++; $display("FAIL midpulse_block: got %0d cols %0d mismatches want 1060/0", got.size(), n);
        end
        checks++;
        if ({er[499], er[500], er[1076]} !== 3'b011) begin
            errors++; $display("FAIL midpulse_err: got %b want 011", {er[499], er[500], er[1076]});
        end
    endtask

    task automatic test_eop_collision();
        do_reset();
        gen_stim(1056, 1);
        build_expected(1056);
        run_block(1'b0, 1056 + 20, 1063);
        checks++;
        if (got.size() !== 1060) begin
            errors++; $display("FAIL eop_collide_count: got %0d want 1060", got.size());
        end
        checks++;
        if ({er[1062], er[1063], bz[1070]} !== 3'b010) begin
            errors++; $display("FAIL eop_collide_err: got %b want 010", {er[1062], er[1063], bz[1070]});
        end
    endtask

    task automatic test_abort();
        int n, fi;
        logic [7:0] obs;
        do_reset();
        gen_stim(6144, 1);
        run_block(1'b1, 300, -1);
        checks++;
        if (got.size() !== 300) begin
            errors++; $display("FAIL abort_pre_count: got %0d want 300", got.size());
        end
        aclr = 1'b1;
        #1;
        obs = {bus.d0, bus.d1, bus.d2, bus.out_valid, bus.sop, bus.eop, bus.busy, bus.err};
        checks++;
        if (obs !== 8'h00) begin
            errors++; $display("FAIL abort_outputs: got %b want 00000000", obs);
        end
        @(negedge clk);
        @(negedge clk);
        aclr = 1'b0;
        gen_stim(1056, 1);
        build_expected(1056);
        run_block(1'b0, 1056 + 12, -1);
        n = count_mismatch(fi);
        checks++;
        if (got.size() !== 1060 || n !== 0 || er[1068] !== 1'b0) begin
            errors++;
            $display("FAIL abort_restart: got %0d cols %0d mismatches err=%b want 1060/0/0", got.size(), n, er[1068]);
        end
    endtask

    task automatic test_back_to_back();
        int n, fi, c1;
        bit b_last, b_eop;
        do_reset();
        gen_stim(1056, 1);
        build_expected(1056);
        run_block(1'b0, 1056 + 7, -1);
        n      = count_mismatch(fi);
        c1     = got.size();
        b_last = bz[1062];
        b_eop  = bz[1063];
        checks++;
        if (c1 !== 1060 || n !== 0) begin
            errors++; $display("FAIL b2b_first: got %0d cols %0d mismatches want 1060/0", c1, n);
        end
        gen_stim(1056, 1);
        build_expected(1056);
        run_block(1'b0, 1056 + 12, -1);
        n = count_mismatch(fi);
        checks++;
        if (got.size() !== 1060 || n !== 0) begin
            errors++; $display("FAIL b2b_second: got %0d cols %0d mismatches want 1060/0", got.size(), n);
        end
        checks++;
        if ({b_last, b_eop, bz[0], er[1068]} !== 4'b1010) begin
            errors++; $display("FAIL b2b_busy_err: got %b want 1010", {b_last, b_eop, bz[0], er[1068]});
        end
    endtask

`ifdef TURBO_OUTPUT_MUX_DEBUG_EN
    task automatic test_debug();
        do_reset();
        gen_stim(1056, 1);
        run_block(1'b0, 1056 + 10, -1);
        checks++;
        if (dbg_state[0] !== 1 || dbg_state[1055] !== 1 || dbg_state[1056] !== 2 ||
            dbg_state[1059] !== 3 || dbg_state[1062] !== 3 || dbg_state[1063] !== 0) begin
            errors++;
            $display("FAIL debug_state: got %0d %0d %0d %0d %0d %0d want 1 1 2 3 3 0", dbg_state[0],
                     dbg_state[1055], dbg_state[1056], dbg_state[1059], dbg_state[1062], dbg_state[1063]);
        end
        checks++;
        if (dbg_cnt[1056] !== 1056) begin
            errors++; $display("FAIL debug_cnt: got %0d want 1056", dbg_cnt[1056]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_k0_pattern();
        test_k1_random();
        test_err_midblock();
        test_eop_collision();
        test_abort();
        test_back_to_back();
`ifdef TURBO_OUTPUT_MUX_DEBUG_EN
        test_debug();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
